sort_sequencer: RTL and testbench

Bus master for the 16x8 sort data memory. On `start`, it reads the element count ("last" index) from the memory. It then bubble-sorts the array in place, ascending, using the memory's combinational read port and its clocked single-word write port. It drives the memory's read select, write select, write data and write enable (c17), and reports busy, done and a swap count to the top-level controller.

---
 rtl/sort_pkg.sv | 21 ++
 rtl/sort_sequencer.sv | 132 +++++++++++++
 tb/tb_sort_sequencer.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/sort_pkg.sv
// Shared definitions for the sort sequencer and the sort data memory's reset image.
package sort_pkg;

    localparam int SORT_DATA_W    = 8;
    localparam int SORT_ADDR_W    = 4;
    localparam int SORT_BASE_ADDR = 0;
    localparam int SORT_LEN_ADDR  = 8;
    localparam int SORT_MAX_LAST  = 7;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_LAST,
        READ_A,
        READ_B,
        WRITE_A,
        WRITE_B,
        STEP,
        FINISH
    } state_t;

endpackage

// File: rtl/sort_sequencer.sv
// In-place ascending bubble sort master for the 16x8 sort memory.
// 3 cycles per compare, 5 with a swap; start is ignored unless IDLE.
module sort_sequencer
    import sort_pkg::*;
#(
    parameter int DATA_W    = SORT_DATA_W,
    parameter int ADDR_W    = SORT_ADDR_W,
    parameter int BASE_ADDR = SORT_BASE_ADDR,
    parameter int LEN_ADDR  = SORT_LEN_ADDR,
    parameter int MAX_LAST  = SORT_MAX_LAST
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_raddr,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] swap_count
);

    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LEN      = ADDR_W'(LEN_ADDR);
    localparam logic [DATA_W-1:0] LIMIT    = DATA_W'(MAX_LAST);
    localparam logic [DATA_W-1:0] ALL_ONES = '1;

    state_t            state;
    logic [ADDR_W-1:0] i;
    logic [DATA_W-1:0] bound;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              swapped;

    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
    logic [DATA_W-1:0] last_clamped;
    logic [DATA_W:0]   i_inc;

    assign addr_a       = BASE + i;
    assign addr_b       = addr_a + ADDR_W'(1);
    assign last_clamped = (mem_rdata > LIMIT) ? LIMIT : mem_rdata;
    // Widened so the pass-end test cannot wrap when i is near its maximum.
    assign i_inc        = (DATA_W+1)'(i) + (DATA_W+1)'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            i          <= '0;
            bound      <= '0;
            a          <= '0;
            b          <= '0;
            swapped    <= 1'b0;
            swap_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        swap_count <= '0;
                        state      <= LOAD_LAST;
                    end
                end
                LOAD_LAST: begin
                    bound   <= last_clamped;
                    i       <= '0;
                    swapped <= 1'b0;
                    state   <= (last_clamped == '0) ? FINISH : READ_A;
                end
                READ_A: begin
                    a     <= mem_rdata;
                    state <= READ_B;
                end
                READ_B: begin
                    b     <= mem_rdata;
                    state <= (a > mem_rdata) ? WRITE_A : STEP;
                end
                WRITE_A: state <= WRITE_B;
                WRITE_B: begin
                    swapped <= 1'b1;
                    if (swap_count != ALL_ONES)
                        swap_count <= swap_count + DATA_W'(1);
                    state <= STEP;
                end
                STEP: begin
                    if (i_inc < {1'b0, bound}) begin
                        i     <= i + ADDR_W'(1);
                        state <= READ_A;
                    end else if (!swapped || bound == DATA_W'(1)) begin
                        state <= FINISH;
                    end else begin
                        bound   <= bound - DATA_W'(1);
                        i       <= '0;
                        swapped <= 1'b0;
                        state   <= READ_A;
                    end
                end
                FINISH:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        mem_raddr = '0;
        mem_waddr = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        done      = 1'b0;
        case (state)
            LOAD_LAST: mem_raddr = LEN;
            READ_A:    mem_raddr = addr_a;
            READ_B:    mem_raddr = addr_b;
            WRITE_A: begin
                mem_we    = 1'b1;
                mem_waddr = addr_a;
                mem_wdata = b;
            end
            WRITE_B: begin
                mem_we    = 1'b1;
                mem_waddr = addr_b;
                mem_wdata = a;
            end
            FINISH:  done = 1'b1;
            default: ;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_sort_sequencer.sv
// Bench for sort_sequencer: behavioural memory, array-level sort model, per-scenario tasks.
module tb_sort_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] mem_rdata;
    logic [3:0] mem_raddr;
    logic [3:0] mem_waddr;
    logic [7:0] mem_wdata;
    logic       mem_we;
    logic       busy;
    logic       done;
    logic [7:0] swap_count;

    logic [7:0] mem     [16];
    logic [7:0] exp_mem [16];
    int exp_swaps, exp_cycles, exp_last;
    int run_cyc, run_writes;
    int nchk = 0;
    int nerr = 0;

    sort_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mem_rdata  (mem_rdata),
        .mem_raddr  (mem_raddr),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .busy       (busy),
        .done       (done),
        .swap_count (swap_count)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_raddr];
    always @(posedge clk) if (mem_we) mem[mem_waddr] <= mem_wdata;

    // Element 0 is the most significant byte of img.
    task automatic load(input logic [63:0] img, input logic [7:0] last);
        for (int k = 0; k < 8; k++) mem[k] = img[63-8*k -: 8];
        mem[8] = last;
        for (int k = 9; k < 16; k++) mem[k] = 8'($urandom_range(0, 255));
    endtask

    // Reference: plain-array bubble sort with early exit, plus cycle cost.
    task automatic model();
        int bnd;
        bit sw;
        logic [7:0] t;
        for (int k = 0; k < 16; k++) exp_mem[k] = mem[k];
        exp_last   = (mem[8] > 8'd7) ? 7 : int'(mem[8]);
        exp_swaps  = 0;
        exp_cycles = 2;
        bnd = exp_last;
        while (bnd > 0) begin
            sw = 0;
            for (int k = 0; k < bnd; k++) begin
                exp_cycles += 3;
                if (exp_mem[k] > exp_mem[k+1]) begin
                    t = exp_mem[k]; exp_mem[k] = exp_mem[k+1]; exp_mem[k+1] = t;
                    sw = 1;
                    exp_swaps++;
                    exp_cycles += 2;
                end
            end
            if (!sw || bnd == 1) break;
            bnd--;
        end
    endtask

    task automatic run_sort(input string name, input bit poke_start);
        int cyc;
        bit busy_ok, bad_write;
        model();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 1; run_writes = 0; busy_ok = 1; bad_write = 0;
        while (!done && cyc < 3000) begin
            if (!busy) busy_ok = 0;
            if (mem_we) begin
                run_writes++;
                if (int'(mem_waddr) > exp_last) bad_write = 1;
            end
            @(negedge clk);
            cyc++;
            start = poke_start && (cyc % 4 == 1);
        end
        run_cyc = cyc;
        nchk++; if (done !== 1'b1) begin nerr++; $display("FAIL %s done_timeout: no done within %0d cycles", name, cyc); end
        nchk++; if (busy !== 1'b1) begin nerr++; $display("FAIL %s busy_at_done: got %b expected 1", name, busy); end
        nchk++; if (cyc != exp_cycles) begin nerr++; $display("FAIL %s done_cycle: got %0d expected %0d", name, cyc, exp_cycles); end
        nchk++; if (swap_count !== 8'(exp_swaps)) begin nerr++; $display("FAIL %s swap_count: got %0d expected %0d", name, swap_count, exp_swaps); end
        nchk++; if (run_writes != 2*exp_swaps) begin nerr++; $display("FAIL %s write_count: got %0d expected %0d", name, run_writes, 2*exp_swaps); end
        nchk++; if (bad_write) begin nerr++; $display("FAIL %s write_range: write above index %0d seen, expected none", name, exp_last); end
        nchk++; if (!busy_ok) begin nerr++; $display("FAIL %s busy_during_sort: got 0 expected 1", name); end
        start = poke_start;
        @(negedge clk); start = 1'b0;
        nchk++; if (busy !== 1'b0 || done !== 1'b0) begin nerr++; $display("FAIL %s after_done: busy=%b done=%b expected 0 0", name, busy, done); end
        nchk++; if (swap_count !== 8'(exp_swaps)) begin nerr++; $display("FAIL %s swap_hold: got %0d expected %0d", name, swap_count, exp_swaps); end
        for (int k = 0; k < 16; k++) begin
            nchk++;
            if (mem[k] !== exp_mem[k]) begin nerr++; $display("FAIL %s mem[%0d]: got %0d expected %0d", name, k, mem[k], exp_mem[k]); end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0;
        load({8'd7, 8'd3, 8'd2, 8'd1, 8'd6, 8'd4, 8'd5, 8'd8}, 8'd7);
        repeat (2) @(negedge clk);
        nchk++; if (busy !== 1'b0 || done !== 1'b0 || mem_we !== 1'b0) begin nerr++; $display("FAIL reset_ctrl: busy=%b done=%b we=%b expected 0 0 0", busy, done, mem_we); end
        nchk++; if (mem_raddr !== 4'd0 || mem_waddr !== 4'd0) begin nerr++; $display("FAIL reset_addr: raddr=%0d waddr=%0d expected 0 0", mem_raddr, mem_waddr); end
        nchk++; if (mem_wdata !== 8'd0 || swap_count !== 8'd0) begin nerr++; $display("FAIL reset_data: wdata=%0d swaps=%0d expected 0 0", mem_wdata, swap_count); end
        reset = 1'b1;
    endtask

    task automatic test_reference_image();
        load({8'd7, 8'd3, 8'd2, 8'd1, 8'd6, 8'd4, 8'd5, 8'd8}, 8'd7);
        run_sort("reference", 1'b0);
        nchk++; if (swap_count !== 8'd11) begin nerr++; $display("FAIL reference_swaps: got %0d expected 11", swap_count); end
        for (int k = 0; k < 8; k++) begin
            nchk++;
            if (mem[k] !== 8'(k + 1)) begin nerr++; $display("FAIL reference_sorted[%0d]: got %0d expected %0d", k, mem[k], k + 1); end
        end
    endtask

    task automatic test_presorted();
        load({8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8}, 8'd7);
        run_sort("presorted", 1'b0);
        nchk++; if (run_cyc != 23) begin nerr++; $display("FAIL presorted_latency: got %0d expected 23", run_cyc); end
        nchk++; if (run_writes != 0) begin nerr++; $display("FAIL presorted_writes: got %0d expected 0", run_writes); end
    endtask

    task automatic test_zero_last();
        load({$urandom, $urandom}, 8'd0);
        run_sort("zero_last", 1'b0);
        nchk++; if (run_cyc != 2) begin nerr++; $display("FAIL zero_last_latency: got %0d expected 2", run_cyc); end
    endtask

    task automatic test_clamp();
        load({$urandom, $urandom}, 8'd12);
        run_sort("clamp", 1'b0);
        nchk++; if (mem[8] !== 8'd12) begin nerr++; $display("FAIL clamp_len_word: got %0d expected 12", mem[8]); end
    endtask

    task automatic test_duplicates();
        load({8'd5, 8'd5, 8'd2, 8'd2, 8'd9, 8'd0, 8'd9, 8'd1}, 8'd7);
        run_sort("duplicates", 1'b0);
        nchk++; if (swap_count !== 8'd15) begin nerr++; $display("FAIL duplicates_swaps: got %0d expected 15", swap_count); end
    endtask

    task automatic test_start_while_busy();
        load({8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2}, 8'd7);
        run_sort("start_busy", 1'b1);
    endtask

    task automatic test_random();
        logic [63:0] img;
        for (int n = 0; n < 6; n++) begin
            for (int k = 0; k < 8; k++)
                img[63-8*k -: 8] = (n % 2 == 1) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
            load(img, 8'($urandom_range(0, 15)));
            run_sort($sformatf("random%0d", n), n == 3);
        end
    endtask

    task automatic test_reset_mid_sort();
        int w;
        load({8'd7, 8'd3, 8'd2, 8'd1, 8'd6, 8'd4, 8'd5, 8'd8}, 8'd7);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        w = 0;
        while (!mem_we && w < 100) begin @(negedge clk); w++; end
        nchk++; if (mem_we !== 1'b1) begin nerr++; $display("FAIL midreset_reach_write: no write within %0d cycles", w); end
        reset = 1'b0;
        #1;
        nchk++; if (busy !== 1'b0 || mem_we !== 1'b0 || done !== 1'b0) begin nerr++; $display("FAIL midreset_ctrl: busy=%b we=%b done=%b expected 0 0 0", busy, mem_we, done); end
        nchk++; if (swap_count !== 8'd0) begin nerr++; $display("FAIL midreset_swaps: got %0d expected 0", swap_count); end
        @(negedge clk); reset = 1'b1;
        run_sort("after_reset", 1'b0);
    endtask

    initial begin
        test_reset();
        test_reference_image();
        test_presorted();
        test_zero_last();
        test_clamp();
        test_duplicates();
        test_start_while_busy();
        test_random();
        test_reset_mid_sort();
        $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
        $finish;
    end

endmodule
